// File: rtl/bus_decoder_pkg.sv
// Shared definitions for bus_transaction_decoder and its aperture matcher.
//   state_e      : transaction FSM encoding (IDLE, ACCESS, DONE)
//   get_field    : pull field idx of width w out of a packed parameter vector
//   cnt_width    : wait-state counter width for a given timeout (min 1 bit)
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Packed parameter vectors are widened to this many bits before extraction.
  localparam int FIELD_VEC_W = 1024;

  function automatic logic [31:0] get_field(input logic [FIELD_VEC_W-1:0] vec,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [FIELD_VEC_W-1:0] shifted;
    shifted = vec >> (idx * w);
    return shifted[31:0] & ((w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
  endfunction

  function automatic int cnt_width(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bus_transaction_decoder_match.sv
// aperture_match: combinational base/aperture decode.
//   a_i   : decoded request address
//   sel_o : one-hot winner, lowest matching index
//   any_o : at least one device matches
// Device i matches when the address bits above its aperture width equal the
// same bits of its base; an aperture width >= a_bits matches everything.
module aperture_match
  import bus_decoder_pkg::*;
#(
  parameter int a_bits  = 16,
  parameter int B       = 16,
  parameter int A       = 4,
  parameter int devices = 1,
  parameter logic [devices*B-1:0] base_addresses  = '0,
  parameter logic [devices*A-1:0] aperture_widths = '0
) (
  input  logic [a_bits-1:0]  a_i,
  output logic [devices-1:0] sel_o,
  output logic               any_o
);

  always_comb begin
    logic [B-1:0]      base_i;
    logic [A-1:0]      w_i;
    logic [a_bits-1:0] mask;
    base_i = '0;
    w_i    = '0;
    mask   = '0;
    sel_o  = '0;
    any_o  = 1'b0;
    for (int i = 0; i < devices; i++) begin
      base_i = B'(get_field(FIELD_VEC_W'(base_addresses), i, B));
      w_i    = A'(get_field(FIELD_VEC_W'(aperture_widths), i, A));
      mask   = {a_bits{1'b1}} << w_i;
      if (!any_o && (((a_i ^ base_i[a_bits-1:0]) & mask) == '0)) begin
        sel_o[i] = 1'b1;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_transaction_decoder.sv
// bus_transaction_decoder: registered, handshaked bus decoder. Accepts one
// request at a time, strobes the lowest-index matching device until it acks
// or the wait-state timeout expires, then returns a one-cycle response.
// Ports: clk, reset (async, active-high); req_* request side; resp_* response
// side; dev_* device side (strobes held until ack, acks, packed read data).
// Optional: define BUS_DECODER_ERR_EN to add resp_err and err_count.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// ACCESS | winner's strobe held, waiting for ack or timeout
// DONE   | resp_valid=1 for one cycle
module bus_transaction_decoder
  import bus_decoder_pkg::*;
#(
  parameter int D       = 8,
  parameter int B       = 16,
  parameter int A       = 4,
  parameter int a_bits  = B,
  parameter int devices = 1,
  parameter logic [devices*B-1:0] base_addresses  = '0,
  parameter logic [devices*A-1:0] aperture_widths = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [a_bits-1:0]      req_a,
  input  logic [D-1:0]           req_wdata,
  output logic                   resp_valid,
  output logic [D-1:0]           resp_data,
  output logic [a_bits-1:0]      dev_a,
  output logic [D-1:0]           dev_wdata,
  output logic [devices-1:0]     dev_read_strobes,
  output logic [devices-1:0]     dev_write_strobes,
  input  logic [devices-1:0]     dev_acks,
  input  logic [D*devices-1:0]   dev_read_datas
`ifdef BUS_DECODER_ERR_EN
  ,
  output logic                   resp_err,
  output logic [7:0]             err_count
`endif
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [a_bits-1:0]   a_q, a_d;
  logic [D-1:0]        wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [devices-1:0]  sel_q, sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [D-1:0]        rdata_q, rdata_d;

  logic [devices-1:0]  hit_sel;
  logic                hit_any;
  logic                ack_sel;
  logic                timeout_hit;
  logic [D-1:0]        sel_rdata;

  aperture_match #(
    .a_bits         (a_bits),
    .B              (B),
    .A              (A),
    .devices        (devices),
    .base_addresses (base_addresses),
    .aperture_widths(aperture_widths)
  ) u_match (
    .a_i  (req_a),
    .sel_o(hit_sel),
    .any_o(hit_any)
  );

  assign ack_sel     = |(dev_acks & sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // sel_q is one-hot, so OR-ing masked slices is the mux.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < devices; i++) begin
      if (sel_q[i]) sel_rdata |= dev_read_datas[i*D +: D];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    wdata_d = wdata_q;
    write_d = write_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          wdata_d = req_wdata;
          write_d = req_write;
          sel_d   = hit_sel;
          cnt_d   = '0;
          if (hit_any) begin
            state_d = ST_ACCESS;
          end else begin
            rdata_d = '1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        if (ack_sel) begin
          rdata_d = write_q ? '1 : sel_rdata;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d = '1;
          state_d = ST_DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = (state_q == ST_DONE);
  assign resp_data         = rdata_q;
  assign dev_a             = a_q;
  assign dev_wdata         = wdata_q;
  assign dev_read_strobes  = (state_q == ST_ACCESS && !write_q) ? sel_q : '0;
  assign dev_write_strobes = (state_q == ST_ACCESS &&  write_q) ? sel_q : '0;

`ifdef BUS_DECODER_ERR_EN
  logic       err_q, err_d;
  logic [7:0] errcnt_q, errcnt_d;
  logic       err_evt;

  // Errors are a miss on accept or a timeout without ack.
  assign err_evt = (state_q == ST_IDLE && req_valid && !hit_any) ||
                   (state_q == ST_ACCESS && !ack_sel && timeout_hit);

  always_comb begin
    err_d    = err_q;
    errcnt_d = errcnt_q;
    if (err_evt) begin
      err_d = 1'b1;
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end else if (state_q == ST_ACCESS && ack_sel) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign resp_err  = err_q;
  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_bus_transaction_decoder.sv
module tb_bus_transaction_decoder;
  localparam int D = 8, B = 16, A = 4, NDEV = 3, TO = 4;
  localparam logic [NDEV*B-1:0] BASES  = {16'hD000, 16'hDE00, 16'hDF00};
  localparam logic [NDEV*A-1:0] WIDTHS = {4'd12, 4'd8, 4'd8};

  logic clk, reset;
  logic req_valid, req_ready, req_write;
  logic [B-1:0] req_a;
  logic [D-1:0] req_wdata;
  logic resp_valid;
  logic [D-1:0] resp_data;
  logic [B-1:0] dev_a;
  logic [D-1:0] dev_wdata;
  logic [NDEV-1:0] dev_read_strobes, dev_write_strobes, dev_acks;
  logic [D*NDEV-1:0] dev_read_datas;
`ifdef BUS_DECODER_ERR_EN
  logic resp_err;
  logic [7:0] err_count;
`endif

  bus_transaction_decoder #(
    .D(D), .B(B), .A(A), .a_bits(B), .devices(NDEV),
    .base_addresses(BASES), .aperture_widths(WIDTHS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_a(req_a), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .dev_a(dev_a), .dev_wdata(dev_wdata),
    .dev_read_strobes(dev_read_strobes), .dev_write_strobes(dev_write_strobes),
    .dev_acks(dev_acks), .dev_read_datas(dev_read_datas)
`ifdef BUS_DECODER_ERR_EN
    , .resp_err(resp_err), .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_errs = 0;

  // Reference decode: device i covers [base_i, base_i + 2^W_i), first listed wins.
  int base_m[NDEV] = '{16'hDF00, 16'hDE00, 16'hD000};
  int w_m[NDEV]    = '{8, 8, 12};

  function automatic int model_winner(input int addr);
    for (int i = 0; i < NDEV; i++)
      if (addr >= base_m[i] && addr < base_m[i] + (1 << w_m[i])) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic [15:0] addr, input logic wr,
                         input logic [7:0] wd, input int ack_at, input bit noise,
                         input logic [23:0] rd, input int exp_win, input int exp_n,
                         input logic [7:0] exp_data, input bit exp_err);
    int nstb, serr, cyc;
    bit got;
    logic [NDEV-1:0] em, acks;
    dev_read_datas = rd;
    em = (exp_win < 0) ? '0 : NDEV'(1 << exp_win);
    chk(tag, "ready_idle", req_ready, 1);
    req_valid = 1'b1; req_a = addr; req_write = wr; req_wdata = wd;
    step();
    // Garbage requests while busy must not be accepted.
    req_valid = 1'($urandom_range(0, 1));
    req_a = 16'($urandom); req_wdata = 8'($urandom); req_write = 1'($urandom);
    nstb = 0; serr = 0; cyc = 1; got = 0;
    while (cyc <= 12 && !got) begin
      if (resp_valid) got = 1;
      else begin
        if (req_ready) serr++;
        if (dev_read_strobes !== (wr ? '0 : em)) serr++;
        if (dev_write_strobes !== (wr ? em : '0)) serr++;
        if ((dev_read_strobes | dev_write_strobes) != '0) nstb++;
        acks = noise ? (NDEV'($urandom) & ~em) : '0;
        if (exp_win >= 0 && cyc == ack_at) acks = acks | em;
        dev_acks = acks;
        step();
        dev_acks = '0;
        cyc++;
      end
    end
    req_valid = 1'b0;
    chk(tag, "latency", cyc, exp_n + 1);
    chk(tag, "strobe_cycles", nstb, exp_n);
    chk(tag, "strobe_errs", serr, 0);
    chk(tag, "resp_data", resp_data, exp_data);
    chk(tag, "dev_a", dev_a, addr);
    chk(tag, "dev_wdata", dev_wdata, wd);
`ifdef BUS_DECODER_ERR_EN
    if (exp_err && exp_errs < 255) exp_errs++;
    chk(tag, "resp_err", resp_err, exp_err);
    chk(tag, "err_count", err_count, exp_errs);
`endif
    step();
    chk(tag, "resp_pulse", resp_valid, 0);
    chk(tag, "resp_hold", resp_data, exp_data);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wd;
    int          ack_at;
    bit          noise;
    int          win;
    int          n;
    logic [7:0]  data;
    bit          err;
  } vec_t;

  vec_t tbl[10];
  localparam logic [23:0] RD_FIX = {8'h11, 8'h22, 8'h5A};

  initial begin
    int win, n, miss_cnt;
    logic [15:0] ra;
    logic wr;
    logic [7:0] wd, dat;
    logic [23:0] rd;
    int ack_at;
    bit acked;

    tbl[0] = '{16'hDF05, 1'b0, 8'h00, 1, 1'b0, 0, 1, 8'h5A, 1'b0};
    tbl[1] = '{16'hDE10, 1'b0, 8'h00, 2, 1'b1, 1, 2, 8'h22, 1'b0};
    tbl[2] = '{16'hD400, 1'b1, 8'h3C, 3, 1'b0, 2, 3, 8'hFF, 1'b0};
    tbl[3] = '{16'hC000, 1'b0, 8'h00, 0, 1'b0, -1, 0, 8'hFF, 1'b1};
    tbl[4] = '{16'hDF00, 1'b0, 8'h00, 0, 1'b0, 0, 4, 8'hFF, 1'b1};
    tbl[5] = '{16'hDF00, 1'b0, 8'h00, 4, 1'b0, 0, 4, 8'h5A, 1'b0};
    tbl[6] = '{16'hDE80, 1'b0, 8'h00, 5, 1'b1, 1, 4, 8'hFF, 1'b1};
    tbl[7] = '{16'hDFFF, 1'b1, 8'hA5, 1, 1'b1, 0, 1, 8'hFF, 1'b0};
    tbl[8] = '{16'hD000, 1'b0, 8'h00, 2, 1'b1, 2, 2, 8'h11, 1'b0};
    tbl[9] = '{16'hE000, 1'b0, 8'h00, 1, 1'b1, -1, 0, 8'hFF, 1'b1};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_a = '0; req_wdata = '0;
    dev_acks = '0; dev_read_datas = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset", "req_ready", req_ready, 1);
    chk("reset", "resp_valid", resp_valid, 0);
    chk("reset", "resp_data", resp_data, 8'hFF);
    chk("reset", "dev_a", dev_a, 0);
    chk("reset", "dev_wdata", dev_wdata, 0);
    chk("reset", "strobes", {dev_read_strobes, dev_write_strobes}, 0);

    for (int i = 0; i < 10; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].ack_at,
              tbl[i].noise, RD_FIX, tbl[i].win, tbl[i].n, tbl[i].data, tbl[i].err);

    // Reset in the middle of an access: strobe drops at once, no response.
    req_valid = 1'b1; req_a = 16'hDF00; req_write = 1'b0; req_wdata = 8'h77;
    step();
    req_valid = 1'b0;
    chk("midrst", "strobe_before", dev_read_strobes, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("midrst", "strobe_async", {dev_read_strobes, dev_write_strobes}, 0);
    chk("midrst", "resp_valid_async", resp_valid, 0);
    step();
    reset = 1'b0;
    exp_errs = 0;
    miss_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) miss_cnt++;
      step();
    end
    chk("midrst", "no_resp", miss_cnt, 0);
    chk("midrst", "req_ready", req_ready, 1);
    chk("midrst", "resp_data", resp_data, 8'hFF);
    chk("midrst", "dev_a", dev_a, 0);
    chk("midrst", "dev_wdata", dev_wdata, 0);
`ifdef BUS_DECODER_ERR_EN
    chk("midrst", "err_count", err_count, 0);
`endif
    run_txn("after_rst", tbl[0].addr, tbl[0].wr, tbl[0].wd, tbl[0].ack_at, tbl[0].noise,
            RD_FIX, tbl[0].win, tbl[0].n, tbl[0].data, tbl[0].err);

    for (int k = 0; k < 60; k++) begin
      ra = 16'hC000 + 16'($urandom_range(0, 16'h2FFF));
      if (k % 4 == 0) ra = 16'hDE00 + 16'($urandom_range(0, 16'h01FF));
      wr = 1'($urandom);
      wd = 8'($urandom);
      rd = 24'($urandom);
      ack_at = $urandom_range(0, 6);
      win = model_winner(int'(ra));
      acked = (win >= 0) && ack_at >= 1 && ack_at <= TO;
      n = (win < 0) ? 0 : (acked ? ack_at : TO);
      dat = 8'hFF;
      if (acked && !wr) dat = rd[win*8 +: 8];
      run_txn($sformatf("rnd%0d", k), ra, wr, wd, ack_at, 1'b1, rd, win, n, dat, !acked);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
